// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM states, grant encodings and full-word lane mask for mem_port_arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_FETCH = 2'd1;
  localparam logic [1:0] GNT_DATA = 2'd2;
  localparam logic [3:0] SEL_WORD = 4'b1111;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch (if_*) and load/store (mem_*) ports, data first; ram_* drives the RAM, busy_o flags a transaction in flight
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);
  localparam int CW = (RAM_LATENCY < 1) ? 1 : $clog2(RAM_LATENCY + 1);
  state_t state, state_nxt;
  logic [1:0] gnt;
  logic [CW-1:0] cnt;
  logic we;
  logic [3:0] sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic cap;
  always_comb begin
    state_nxt = state;
    cap = 1'b0;
    case (state)
      IDLE: state_nxt = (mem_req_i || if_req_i) ? ISSUE : IDLE;
      ISSUE: begin
        cap = !we && RAM_LATENCY == 0;
        state_nxt = (we || RAM_LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cap = cnt == CW'(1);
        state_nxt = cap ? RESP : WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= GNT_NONE;
      cnt <= '0;
      we <= 1'b0;
      sel <= '0;
      addr <= '0;
      wdata <= '0;
      if_data_o <= '0;
      mem_rdata_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_req_i) begin
        gnt <= GNT_DATA;
        we <= mem_we_i;
        sel <= mem_sel_i;
        addr <= mem_addr_i;
        wdata <= mem_wdata_i;
      end else if (state == IDLE && if_req_i) begin
        gnt <= GNT_FETCH;
        we <= 1'b0;
        sel <= SEL_WORD;
        addr <= if_addr_i;
        wdata <= '0;
      end else if (state == RESP) begin
        gnt <= GNT_NONE;
      end
      if (state == ISSUE) cnt <= CW'(RAM_LATENCY);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (cap && gnt == GNT_DATA) mem_rdata_o <= ram_rdata_i;
      if (cap && gnt == GNT_FETCH) if_data_o <= ram_rdata_i;
    end
  end
  assign ram_ce_o = state == ISSUE || state == WAIT;
  assign ram_we_o = state == ISSUE && we;
  assign ram_sel_o = sel;
  assign ram_addr_o = addr;
  assign ram_wdata_o = wdata;
  assign if_ready_o = state == RESP && gnt == GNT_FETCH;
  assign mem_ready_o = state == RESP && gnt == GNT_DATA;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench against a transaction-level schedule model
module tb_mem_port_arbiter;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic if_req, mem_req, mem_we, if_ready, mem_ready, ram_ce, ram_we, busy;
  logic [3:0] mem_sel, ram_sel;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_data, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic z_if_req, z_mem_req, z_mem_we, z_if_ready, z_mem_ready, z_ram_ce, z_ram_we, z_busy;
  logic [3:0] z_mem_sel, z_ram_sel;
  logic [31:0] z_if_addr, z_mem_addr, z_mem_wdata, z_if_data, z_mem_rdata, z_ram_addr, z_ram_wdata, z_ram_rdata, z_word;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .busy_o(busy)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req_i(z_if_req), .if_addr_i(z_if_addr), .if_data_o(z_if_data), .if_ready_o(z_if_ready),
    .mem_req_i(z_mem_req), .mem_we_i(z_mem_we), .mem_sel_i(z_mem_sel), .mem_addr_i(z_mem_addr),
    .mem_wdata_i(z_mem_wdata), .mem_rdata_o(z_mem_rdata), .mem_ready_o(z_mem_ready),
    .ram_ce_o(z_ram_ce), .ram_we_o(z_ram_we), .ram_sel_o(z_ram_sel), .ram_addr_o(z_ram_addr),
    .ram_wdata_o(z_ram_wdata), .ram_rdata_i(z_ram_rdata), .busy_o(z_busy)
  );
  assign z_ram_rdata = z_ram_ce ? z_word : 32'hBAD0BAD0;
  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction
  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'($urandom_range(0, 7)) * 4;
  endfunction
  logic [31:0] ram_mem [32];
  bit written [32];
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return written[a[6:2]] ? ram_mem[a[6:2]] : init_word(int'(a[6:2]));
  endfunction
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      ram_mem[ram_addr[6:2]] <= merge(ram_rd(ram_addr), ram_wdata, ram_sel);
      written[ram_addr[6:2]] <= 1'b1;
    end
    ram_rdata <= ram_ce ? ram_rd(ram_addr) : $urandom;
  end
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  logic [31:0] model_mem [32];
  bit f_active, m_active, m_is_wr, g_we;
  int f_done, m_done, g_cyc, g_done, idle_from;
  logic [31:0] f_exp, m_exp, g_addr, g_wdata, exp_if_data, exp_mem_rdata;
  logic [3:0] g_sel;
  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = init_word(i);
    {if_req, mem_req, mem_we, mem_sel, if_addr, mem_addr, mem_wdata} = '0;
    {z_if_req, z_mem_req, z_mem_we, z_mem_sel, z_if_addr, z_mem_addr, z_mem_wdata, z_word} = '0;
    repeat (2) step();
    chk("rst_ce", ram_ce, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_addr", ram_addr, 0);
    rst = 1'b0;
    mem_req = 1'b1;
    mem_addr = 32'h104;
    mem_sel = 4'hF;
    step();
    chk("abort_issue_ce", ram_ce, 1);
    step();
    chk("abort_wait_ce", ram_ce, 1);
    rst = 1'b1;
    mem_req = 1'b0;
    step();
    chk("abort_ce", ram_ce, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mem_ready", mem_ready, 0);
    chk("abort_mem_rdata", mem_rdata, 0);
    chk("abort_sel", ram_sel, 0);
    rst = 1'b0;
    f_active = 1'b1;
    m_active = 1'b0;
    m_is_wr = 1'b0;
    if_addr = 32'h0;
    f_done = -1;
    m_done = -1;
    g_cyc = -10;
    g_done = -10;
    g_we = 1'b0;
    idle_from = cyc;
    exp_if_data = '0;
    exp_mem_rdata = '0;
    repeat (1500) begin
      chk("if_ready", if_ready, cyc == f_done);
      chk("mem_ready", mem_ready, cyc == m_done);
      chk("busy", busy, cyc > g_cyc && cyc <= g_done);
      chk("ram_ce", ram_ce, cyc > g_cyc && cyc < g_done);
      chk("ram_we", ram_we, g_we && cyc == g_cyc + 1);
      if (cyc == g_cyc + 1) begin
        chk("ram_addr", ram_addr, g_addr);
        chk("ram_sel", ram_sel, g_sel);
        if (g_we) chk("ram_wdata", ram_wdata, g_wdata);
      end
      if (cyc == f_done) exp_if_data = f_exp;
      if (cyc == m_done && !m_is_wr) exp_mem_rdata = m_exp;
      chk("if_data", if_data, exp_if_data);
      chk("mem_rdata", mem_rdata, exp_mem_rdata);
      if (cyc == f_done) f_active = 1'b0;
      if (cyc == m_done) m_active = 1'b0;
      if (!f_active && $urandom_range(0, 2) != 0) begin
        f_active = 1'b1;
        f_done = -1;
        if_addr = rand_addr();
      end
      if (!m_active && $urandom_range(0, 2) == 0) begin
        m_active = 1'b1;
        m_done = -1;
        mem_we = 1'($urandom_range(0, 1));
        mem_sel = 4'($urandom_range(0, 15));
        mem_addr = rand_addr();
        mem_wdata = $urandom;
      end
      if_req = f_active;
      mem_req = m_active;
      if (cyc >= idle_from && (m_active || f_active)) begin
        g_cyc = cyc;
        if (m_active) begin
          g_we = mem_we;
          g_sel = mem_sel;
          g_addr = mem_addr;
          g_wdata = mem_wdata;
          g_done = cyc + 2 + (mem_we ? 0 : LAT);
          m_done = g_done;
          m_is_wr = mem_we;
          if (mem_we) model_mem[mem_addr[6:2]] = merge(model_mem[mem_addr[6:2]], mem_wdata, mem_sel);
          else m_exp = model_mem[mem_addr[6:2]];
        end else begin
          g_we = 1'b0;
          g_sel = 4'hF;
          g_addr = if_addr;
          g_done = cyc + 2 + LAT;
          f_done = g_done;
          f_exp = model_mem[if_addr[6:2]];
        end
        idle_from = g_done + 1;
      end
      step();
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    z_mem_req = 1'b1;
    z_mem_addr = 32'h40;
    z_mem_sel = 4'hF;
    z_word = 32'h12345678;
    step();
    chk("z_issue_ce", z_ram_ce, 1);
    chk("z_issue_ready", z_mem_ready, 0);
    step();
    chk("z_mem_ready", z_mem_ready, 1);
    chk("z_mem_rdata", z_mem_rdata, 32'h12345678);
    z_mem_req = 1'b0;
    step();
    chk("z_mem_ready_off", z_mem_ready, 0);
    z_if_req = 1'b1;
    z_if_addr = 32'h80;
    z_word = 32'h00000073;
    step();
    chk("z_fetch_sel", z_ram_sel, 4'hF);
    step();
    chk("z_if_ready", z_if_ready, 1);
    chk("z_if_data", z_if_data, 32'h00000073);
    chk("z_mem_rdata_kept", z_mem_rdata, 32'h12345678);
    z_if_req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
